// File: rtl/fifo_reader.sv
// Read-side controller for a byte FIFO: pops one byte per REQ cycle and presents it on a
// valid/ready stream, counting delivered bytes.
module fifo_reader #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 5,
    parameter int unsigned NW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          fifo_empty,
    input  logic [CW-1:0] fifo_cnt,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_rd,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [CW-1:0] level,
    output logic [NW-1:0] rd_count
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic [NW-1:0] rd_count_q, rd_count_d;
    logic [CW-1:0] level_q;
    logic          can_pop;

    // fifo_empty is only looked at in IDLE/HOLD, a full cycle after any pop settles.
    assign can_pop = en && !fifo_empty;

    always_comb begin
        state_d    = state_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        rd_count_d = rd_count_q;
        case (state_q)
            StIdle: begin
                if (can_pop) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                // The FIFO popped on the falling edge; its data_out now holds the byte.
                m_data_d  = fifo_data;
                m_valid_d = 1'b1;
                state_d   = StHold;
            end
            StHold: begin
                if (m_ready) begin
                    m_valid_d  = 1'b0;
                    rd_count_d = rd_count_q + 1'b1;
                    state_d    = can_pop ? StReq : StIdle;
                end
            end
            default: begin
                m_valid_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            rd_count_q <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            rd_count_q <= rd_count_d;
            level_q    <= fifo_cnt;
        end
    end

    assign fifo_rd  = (state_q == StReq);
    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign rd_count = rd_count_q;
    assign level    = level_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a behavioural FIFO feeds the DUT, a monitor checks
// delivered bytes against the queue of bytes written.
module tb_fifo_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 5;
    localparam int unsigned NW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [CW-1:0] fifo_cnt = '0;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [CW-1:0] level;
    logic [NW-1:0] rd_count;

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            rd_pulses = 0;
    int            rd_cycles[$];
    logic [7:0]    fifo_q[$];
    logic [7:0]    exp_q[$];
    logic [7:0]    mon_exp;
    logic          prev_hold = 1'b0;
    logic [7:0]    prev_data = '0;

    fifo_reader #(
        .DW(DW),
        .CW(CW),
        .NW(NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_cnt  (fifo_cnt),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .level     (level),
        .rd_count  (rd_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    // FIFO model and output monitor; the FIFO pops on the falling edge of an rd cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got 0x%0h required none", m_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("m_data_order", 32'(m_data), 32'(mon_exp));
                end
            end
            if (prev_hold) begin
                check("hold_data_stable", 32'(m_data), 32'(prev_data));
                check("hold_valid", 32'(m_valid), 1);
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
        end else begin
            prev_hold = 1'b0;
        end
        if (fifo_rd) begin
            rd_pulses++;
            rd_cycles.push_back(cyc);
            check("pop_nonempty", 32'(fifo_q.size() != 0), 1);
            if (fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
        end
        fifo_empty = (fifo_q.size() == 0);
        fifo_cnt   = CW'(fifo_q.size());
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fifo_q.delete();
        exp_q.delete();
        rd_cycles.delete();
        rd_pulses = 0;
        rst = 1'b1;
    endtask

    task automatic wait_done();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !m_valid && !fifo_rd) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_within_budget", 32'(done), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("valid_within_budget", 32'(seen), 1);
    endtask

    initial begin
        // Reset held with data present and en high.
        @(posedge clk);
        #1 rst = 1'b0;
        en      = 1'b1;
        m_ready = 1'b1;
        push_byte(8'h77);
        repeat (2) begin
            @(negedge clk);
            check("rst_fifo_rd", 32'(fifo_rd), 0);
            check("rst_m_valid", 32'(m_valid), 0);
            check("rst_rd_count", 32'(rd_count), 0);
            check("rst_m_data", 32'(m_data), 0);
            check("rst_level", 32'(level), 0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        rd_pulses = 0;
        @(negedge clk);
        check("release_no_rd_yet", 32'(fifo_rd), 0);
        @(negedge clk);
        check("first_rd_after_release", 32'(fifo_rd), 1);
        wait_done();
        check("rst_test_rd_count", 32'(rd_count), 1);

        // Streaming 0x10..0x1F with m_ready tied high.
        do_reset();
        m_ready = 1'b1;
        en      = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
        @(negedge clk);
        @(negedge clk);
        check("stream_level", 32'(level), 16);
        wait_done();
        check("stream_rd_count", 32'(rd_count), 16);
        check("stream_rd_pulses", rd_pulses, 16);
        check("stream_rd_cycles", rd_cycles.size(), 16);
        for (int i = 1; i < rd_cycles.size(); i++) begin
            check("stream_rd_spacing", rd_cycles[i] - rd_cycles[i-1], 2);
        end
        check("stream_empty_end", 32'(fifo_empty), 1);

        // Backpressure: first byte held for 5 cycles.
        do_reset();
        m_ready = 1'b0;
        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            check("bp_m_data", 32'(m_data), 32'h A1);
            check("bp_m_valid", 32'(m_valid), 1);
            check("bp_no_extra_rd", rd_pulses, 1);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        wait_done();
        check("bp_rd_count", 32'(rd_count), 3);
        check("bp_rd_pulses", rd_pulses, 3);

        // Empty boundary: one byte, then nothing for 20+ cycles.
        do_reset();
        m_ready = 1'b1;
        push_byte(8'h5A);
        repeat (25) @(negedge clk);
        check("empty_rd_pulses", rd_pulses, 1);
        check("empty_m_data", 32'(m_data), 32'h5A);
        check("empty_rd_count", 32'(rd_count), 1);
        check("empty_idle_valid", 32'(m_valid), 0);

        // en dropped during HOLD of the first byte.
        do_reset();
        m_ready = 1'b0;
        en      = 1'b1;
        push_byte(8'h33);
        push_byte(8'h44);
        push_byte(8'h55);
        push_byte(8'h66);
        push_byte(8'h77);
        wait_valid();
        check("en_first_byte", 32'(m_data), 32'h33);
        @(posedge clk);
        #1;
        en      = 1'b0;
        m_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("en_off_rd_pulses", rd_pulses, 1);
        check("en_off_rd_count", 32'(rd_count), 1);
        check("en_off_valid", 32'(m_valid), 0);
        check("en_off_level", 32'(level), 4);
        @(posedge clk);
        #1 en = 1'b1;
        wait_done();
        check("en_resume_rd_count", 32'(rd_count), 5);
        check("en_resume_rd_pulses", rd_pulses, 5);

        // Counter wrap from 0xFFFF.
        do_reset();
        m_ready = 1'b1;
        @(negedge clk);
        force dut.rd_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.rd_count_q;
        @(negedge clk);
        check("wrap_preload", 32'(rd_count), 32'hFFFF);
        @(posedge clk);
        #1 push_byte(8'hC3);
        wait_done();
        check("wrap_rd_count", 32'(rd_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the 16-entry byte FIFO. Pops bytes from the FIFO with single-cycle `rd` strobes, captures the FIFO's `data_out`, and presents each byte on a valid/ready stream to the downstream consumer. Never pops an empty FIFO, never drops or duplicates a byte, and keeps a running count of delivered bytes. Sits between the FIFO read port and any byte consumer (serializer, packer, bus master).

## Interface
- `DW`, 8, data width; matches FIFO `data_out`.
- `CW`, 5, width of FIFO occupancy count.
- `NW`, 16, width of delivered-byte counter.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on rising `clk`, `rst`=0 resets.
- `en`  in  1  permit new pops; 0 lets an in-flight byte complete, then idles.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_cnt`  in  CW  FIFO `cnt`; used only for `level` passthrough.
- `fifo_data`  in  DW  FIFO `data_out`.
- `fifo_rd`  out  1  FIFO `rd` strobe; high exactly one cycle per pop.
- `m_data`  out  DW  delivered byte.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  consumer accepts when `m_valid && m_ready` at rising `clk`.
- `level`  out  CW  registered copy of `fifo_cnt`.
- `rd_count`  out  NW  bytes delivered since reset; wraps modulo 2^NW.

## Operation
- FSM states: IDLE, REQ, HOLD. Reset state IDLE.
- IDLE: if `en && !fifo_empty` -> REQ; else stay.
- REQ: lasts exactly one cycle; `fifo_rd` = (state == REQ), decoded from the state register, glitch-free. The FIFO pops on the falling edge inside this cycle. At the closing rising edge: `m_data <= fifo_data`, `m_valid <= 1`, -> HOLD.
- HOLD: `m_valid` = 1, `m_data` stable until the handshake. On `m_ready` = 1: `m_valid <= 0`, `rd_count <= rd_count + 1`; then -> REQ if `en && !fifo_empty`, else -> IDLE. On `m_ready` = 0: stay, all outputs held.
- Empty guard: `fifo_empty` is only sampled in IDLE/HOLD, at least one full cycle after the previous pop's falling edge, so it always reflects the post-pop state. Never enter REQ with `fifo_empty` = 1.
- `en` falling while in REQ or HOLD: the current byte completes normally, then no further pops.
- `level` <= `fifo_cnt` every cycle; informational only, no control role.
- `rd_count` 0xFFFF + 1 -> 0x0000, no flag.

## Timing
- Reset (`rst`=0 at rising edge): state IDLE, `fifo_rd` 0, `m_valid` 0, `m_data` 0, `rd_count` 0, `level` 0. Reset overrides every other transition.
- Reset while in REQ: the FIFO pop in that cycle still occurs and the byte is discarded. System reset must reset the FIFO concurrently.
- Pop latency: `fifo_rd` high in cycle N -> `m_valid` high from cycle N+1.
- Peak throughput with `m_ready` tied 1: one byte per 2 cycles (REQ, HOLD, REQ, HOLD, ...).
- From IDLE with data present: REQ 1 cycle after `fifo_empty` is seen low.
- FIFO write collision: the FIFO gives `rd` priority, so a write coincident with `fifo_rd` is the writer's concern. This block makes no assumption beyond `fifo_empty` accuracy.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `fifo_empty`=0 and `en`=1 -> `fifo_rd`=0, `m_valid`=0, `rd_count`=0 throughout. First `fifo_rd` occurs 1 cycle after release.
- Streaming: FIFO loaded with 0x10..0x1F, `m_ready`=1 -> 16 bytes out in order 0x10..0x1F, `fifo_rd` pulses exactly 16 times spaced 2 cycles apart, `rd_count`=16, no pop after `fifo_empty`=1.
- Backpressure: 3 bytes queued (0xA1, 0xA2, 0xA3), `m_ready`=0 for 5 cycles then 1 -> `m_data`=0xA1 is held stable 5 cycles with no extra `fifo_rd`, then 0xA2 and 0xA3 follow, `rd_count`=3.
- Empty boundary: single byte 0x5A written, then `fifo_empty`=1 -> exactly one `fifo_rd`, `m_data`=0x5A, FSM returns to IDLE, no further `fifo_rd` for 20 cycles.
- `en` drop: drop `en` during HOLD of byte 0x33 with 4 more bytes queued -> 0x33 delivered, no new `fifo_rd` while `en`=0. Raising `en` resumes with the next byte and nothing is lost.
- Counter wrap: preload via 65 535 deliveries (or force `rd_count`=0xFFFF), deliver one byte -> `rd_count`=0x0000.
